// File: rtl/bit_diff_pkg.sv
// Shared types and width helper for the multi-bit bit-difference engine.
package bit_diff_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

  typedef enum logic {MODE_DIFF = 1'b0, MODE_POP = 1'b1} mode_t;

  // Signed width able to hold -w..+w.
  function automatic int result_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/popcount_slice.sv
// Popcount of BITS inputs; purely combinational, zero latency, no backpressure.
module popcount_slice #(
  parameter int BITS = 4,
  localparam int CW = $clog2(BITS + 1)
) (
  input  logic [BITS-1:0] bits,
  output logic [CW-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < BITS; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/bit_diff_multi.sv
// Ones-minus-zeros / popcount over WIDTH bits, BITS_PER_CYCLE per clock; result WIDTH/BITS_PER_CYCLE cycles after accept,
// held until out_ready (in_ready = out_ready while holding). Macro BIT_DIFF_MULTI_STATS_EN enables the done_count counter.
module bit_diff_multi
  import bit_diff_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int RESULT_W       = result_width(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [RESULT_W-1:0] out_result,
  output logic                       busy,
  output logic [63:0]                done_count
);

  localparam int N      = WIDTH / BITS_PER_CYCLE;
  localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
  localparam int PC_W   = $clog2(BITS_PER_CYCLE + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  state_t                     state;
  mode_t                      mode_r;
  logic [WIDTH-1:0]           shift_r;
  logic [STEP_W-1:0]          step_r;
  logic signed [RESULT_W-1:0] acc_r;
  logic signed [RESULT_W-1:0] pop_ext;
  logic signed [RESULT_W-1:0] incr;
  logic signed [RESULT_W-1:0] acc_next;
  logic [PC_W-1:0]            pc;
  logic                       accept;
  logic                       deliver;

  popcount_slice #(.BITS(BITS_PER_CYCLE)) u_popcount (
    .bits  (shift_r[BITS_PER_CYCLE-1:0]),
    .count (pc)
  );

  // 2*p - BPC may wrap transiently; modular accumulation still lands in -WIDTH..+WIDTH.
  assign pop_ext  = RESULT_W'(pc);
  assign incr     = (mode_r == MODE_POP) ? pop_ext
                                         : (pop_ext <<< 1) - RESULT_W'(BITS_PER_CYCLE);
  assign acc_next = acc_r + incr;

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_r     <= MODE_DIFF;
      shift_r    <= '0;
      step_r     <= '0;
      acc_r      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= COMPUTE;
        end
        COMPUTE: begin
          acc_r   <= acc_next;
          shift_r <= shift_r >> BITS_PER_CYCLE;
          step_r  <= step_r + 1'b1;
          if (step_r == LAST_STEP) begin
            out_result <= acc_next;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (deliver) begin
            out_valid <= 1'b0;
            state     <= in_valid ? COMPUTE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Loading is shared by the IDLE accept and the zero-bubble accept out of HOLD.
      if (accept) begin
        shift_r <= in_data;
        mode_r  <= mode_t'(in_mode);
        acc_r   <= '0;
        step_r  <= '0;
      end
    end
  end

`ifdef BIT_DIFF_MULTI_STATS_EN
  logic [63:0] done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= '0;
    end else if (deliver) begin
      done_r <= done_r + 64'd1;
    end
  end

  assign done_count = done_r;
`else
  assign done_count = '0;
`endif

endmodule

// File: tb/tb_bit_diff_multi.sv
// Directed and random checks of bit_diff_multi at BITS_PER_CYCLE 4, 1 and 32 (WIDTH 32).
module tb_bit_diff_multi;
  import bit_diff_pkg::*;

  localparam int W  = 32;
  localparam int RW = result_width(W);
  localparam int NI = 3;

  function automatic int bpc_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
  endfunction

  localparam logic [31:0] VD [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000,
                                      32'h0000_000F, 32'h0000_000F, 32'hA5A5_A5A5, 32'h8000_0001,
                                      32'hF0F0_F0F0, 32'h7FFF_FFFF};
  localparam bit          VM [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam int          VE [10] = '{32, 32, -32, 0, -24, 4, 0, -28, 16, 30};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [W-1:0] in_data [NI];
  logic signed [RW-1:0] out_result [NI];
  logic [63:0] done_count [NI];
  int hs_cnt [NI];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bit_diff_multi #(.WIDTH(W), .BITS_PER_CYCLE(bpc_of(g))) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .in_mode    (in_mode[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_result (out_result[g]),
      .busy       (busy[g]),
      .done_count (done_count[g])
    );
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) hs_cnt[k] <= 0;
    end else begin
      for (int k = 0; k < NI; k++) if (out_valid[k] && out_ready[k]) hs_cnt[k] <= hs_cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept_word(input int i, input logic [W-1:0] d, input logic m);
    int guard;
    guard = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_mode[i]  = m;
    #1;
    while (!in_ready[i] && guard < 200) begin
      tick();
      #1;
      guard++;
    end
    if (!in_ready[i]) chk("accept_timeout", 0, 1);
    tick();
    in_valid[i] = 1'b0;
    in_data[i]  = $urandom;
    in_mode[i]  = ~m;
  endtask

  task automatic wait_out(input int i, output int lat);
    lat = 0;
    while (!out_valid[i] && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid[i]) chk("result_timeout", 0, 1);
  endtask

  task automatic run_dir(input int i, input int v);
    int lat;
    out_ready[i] = 1'b1;
    accept_word(i, VD[v], VM[v]);
    wait_out(i, lat);
    chk($sformatf("dir%0d_%0d_lat", i, v), lat, W / bpc_of(i));
    chk($sformatf("dir%0d_%0d_res", i, v), out_result[i], VE[v]);
    tick();
    chk($sformatf("dir%0d_%0d_drop", i, v), out_valid[i], 0);
    chk($sformatf("dir%0d_%0d_keep", i, v), out_result[i], VE[v]);
  endtask

  task automatic run_rand(input int i, input int cnt);
    logic [W-1:0] d;
    logic m;
    int exp, lat, guard;
    for (int t = 0; t < cnt; t++) begin
      d = $urandom;
      if (t == 0) d = '0;
      if (t == 1) d = '1;
      m = 1'($urandom_range(0, 1));
      exp = m ? $countones(d) : 2 * $countones(d) - W;
      out_ready[i] = 1'($urandom_range(0, 1));
      accept_word(i, d, m);
      wait_out(i, lat);
      chk($sformatf("rand%0d_lat", i), lat, W / bpc_of(i));
      chk($sformatf("rand%0d_res", i), out_result[i], exp);
      guard = 0;
      while (!out_ready[i]) begin
        tick();
        guard++;
        out_ready[i] = (guard > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      chk($sformatf("rand%0d_hold", i), out_result[i], exp);
      tick();
      chk($sformatf("rand%0d_drop", i), out_valid[i], 0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic flag;
    longint exp_done;
    in_valid  = '0;
    in_mode   = '0;
    out_ready = '0;
    for (int k = 0; k < NI; k++) in_data[k] = '0;

    rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d_valid", k), out_valid[k], 0);
      chk($sformatf("rst%0d_busy", k), busy[k], 0);
      chk($sformatf("rst%0d_res", k), out_result[k], 0);
      chk($sformatf("rst%0d_done", k), done_count[k], 0);
      chk($sformatf("rst%0d_in_ready", k), in_ready[k], 1);
    end
    rst_n = 1'b1;
    tick();

    // Backpressure with a pending word, then zero-bubble accept on release.
    out_ready[0] = 1'b0;
    accept_word(0, 32'h0000_00FF, 1'b0);
    wait_out(0, lat);
    chk("bp_lat", lat, 8);
    chk("bp_res", out_result[0], -16);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'hFFFF_0000;
    in_mode[0]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_stable", out_result[0], -16);
      chk("bp_in_ready", in_ready[0], 0);
      chk("bp_valid", out_valid[0], 1);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready[0], 1);
    tick();
    in_valid[0] = 1'b0;
    in_data[0]  = 32'h0;
    chk("bp_next_valid", out_valid[0], 0);
    chk("bp_next_busy", busy[0], 1);
    wait_out(0, lat);
    chk("bp_next_lat", lat, 8);
    chk("bp_next_res", out_result[0], 16);
    tick();

    // Reset in the middle of a computation.
    accept_word(0, 32'hFFFF_FFFF, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_res", out_result[0], 0);
    chk("mid_rst_done", done_count[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready[0], 1);
    flag = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      flag = flag | out_valid[0] | busy[0];
    end
    chk("post_rst_spurious", flag, 0);

    for (int i = 0; i < NI; i++) begin
      for (int v = 0; v < 10; v++) run_dir(i, v);
    end
`ifdef BIT_DIFF_MULTI_STATS_EN
    exp_done = 10;
`else
    exp_done = 0;
`endif
    for (int i = 0; i < NI; i++) chk($sformatf("done%0d_after10", i), done_count[i], exp_done);

    for (int i = 0; i < NI; i++) run_rand(i, 400);

    tick();
    for (int i = 0; i < NI; i++) begin
`ifdef BIT_DIFF_MULTI_STATS_EN
      exp_done = longint'(hs_cnt[i]);
`else
      exp_done = 0;
`endif
      chk($sformatf("done%0d_final", i), done_count[i], exp_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
